icache_2way: RTL

Parametrised 2-way set-associative, read-only instruction cache with multi-word lines, per-set LRU replacement, sequential line refill over a valid/ready memory port, a whole-cache flush and hit/miss counters. It sits between the instruction-fetch stage and the instruction memory port. Lines are never dirty, so there is no write-back path.

---
 rtl/icache_2way.sv | 123 ++++++++++++
 1 files changed

// File: rtl/icache_2way.sv
// icache_2way: 2-way set-associative read-only instruction cache with per-set LRU, sequential line refill and flush
module icache_2way #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  output logic              cpu_req_ready,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_resp_data,
  input  logic              flush,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_req_ready,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WRD_W = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_W - IDX_W - WRD_W - 2;
  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, RESPOND, FLUSH} state_t;
  state_t state;
  logic [ADDR_W-1:0] addr;
  logic [SETS-1:0] valid [2];
  logic [SETS-1:0] lru;
  logic [TAG_W-1:0] tag_mem [2][SETS];
  logic [DATA_W-1:0] data_mem [2][SETS][LINE_WORDS];
  logic [WRD_W-1:0] cnt;
  logic pend, way;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [WRD_W-1:0] wrd;
  logic h0, h1, hit, victim, last, unused;
  assign tag = addr[ADDR_W-1:WRD_W+IDX_W+2];
  assign idx = addr[WRD_W+IDX_W+1:WRD_W+2];
  assign wrd = addr[WRD_W+1:2];
  assign h0 = valid[0][idx] && tag_mem[0][idx] == tag;
  assign h1 = valid[1][idx] && tag_mem[1][idx] == tag;
  assign hit = h0 || h1;
  assign victim = !valid[0][idx] ? 1'b0 : !valid[1][idx] ? 1'b1 : lru[idx];
  assign last = cnt == WRD_W'(LINE_WORDS - 1);
  assign unused = ^addr[1:0];
  assign cpu_req_ready = state == IDLE && !pend && !flush && !rst;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      pend <= 1'b0;
      valid[0] <= '0;
      valid[1] <= '0;
      lru <= '0;
      addr <= '0;
      cnt <= '0;
      way <= 1'b0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_data <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr <= '0;
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      cpu_resp_valid <= 1'b0;
      if (flush && state inside {LOOKUP, REFILL, RESPOND}) pend <= 1'b1;
      case (state)
        IDLE:
          if (pend || flush) state <= FLUSH;
          else if (cpu_req_valid) begin
            addr <= cpu_req_addr;
            state <= LOOKUP;
          end
        LOOKUP:
          if (hit) begin
            cpu_resp_valid <= 1'b1;
            cpu_resp_data <= data_mem[h1][idx][wrd];
            lru[idx] <= ~h1;
            hit_cnt <= hit_cnt + 32'd1;
            state <= IDLE;
          end else begin
            miss_cnt <= miss_cnt + 32'd1;
            way <= victim;
            valid[victim][idx] <= 1'b0;
            cnt <= '0;
            mem_req_valid <= 1'b1;
            mem_req_addr <= {tag, idx, {WRD_W{1'b0}}, 2'b00};
            state <= REFILL;
          end
        REFILL:
          if (mem_req_ready) begin
            cnt <= cnt + WRD_W'(1);
            mem_req_addr[WRD_W+1:2] <= cnt + WRD_W'(1);
            if (last) begin
              mem_req_valid <= 1'b0;
              valid[way][idx] <= 1'b1;
              lru[idx] <= ~way;
              state <= RESPOND;
            end
          end
        RESPOND: begin
          cpu_resp_valid <= 1'b1;
          cpu_resp_data <= data_mem[way][idx][wrd];
          state <= (pend || flush) ? FLUSH : IDLE;
        end
        FLUSH: begin
          valid[0] <= '0;
          valid[1] <= '0;
          lru <= '0;
          pend <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  // Tag and data arrays carry no reset; a line is only visible once its valid bit is set.
  always_ff @(posedge clk)
    if (!rst && state == REFILL && mem_req_ready) begin
      data_mem[way][idx][cnt] <= mem_req_data;
      if (last) tag_mem[way][idx] <= tag;
    end
endmodule
